// File: rtl/vip_pkg.sv
// Shared types and constants for the median-filter frame controller.
package vip_pkg;

  localparam int W_BITS_DEF = 11;
  localparam int Y_BITS_DEF = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FRAME_WAIT = 2'd1,
    LINE       = 2'd2,
    LINE_GAP   = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_LINE = 2'b01;
  localparam logic [1:0] ERR_ROWS = 2'b10;
  localparam logic [1:0] ERR_BOTH = 2'b11;

endpackage

// File: rtl/vip_edge_detect.sv
// Registers a 1-bit signal and flags its rising and falling edges in the
// cycle the new level is first seen.
module vip_edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_rise,
  output logic o_fall
);

  logic r_sig;

  always_ff @(posedge clk) begin
    if (rst) r_sig <= RST_VAL;
    else     r_sig <= i_sig;
  end

  assign o_rise = i_sig & ~r_sig;
  assign o_fall = ~i_sig & r_sig;

endmodule

// File: rtl/vip_median_frame_ctrl.sv
// Frame controller behind the 3x3 median filter: shadows config per frame,
// tracks pixel position, overrides the border ring and checks geometry.
module vip_median_frame_ctrl
  import vip_pkg::*;
#(
  parameter int W_BITS    = W_BITS_DEF,
  parameter int Y_BITS    = Y_BITS_DEF,
  parameter int FCNT_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_BITS-1:0]    cfg_width,
  input  logic [W_BITS-1:0]    cfg_height,
  input  logic                 cfg_border_mode,
  input  logic [Y_BITS-1:0]    cfg_border_val,
  input  logic                 err_clr,
  input  logic                 in_frame_vsync,
  input  logic                 in_frame_href,
  input  logic                 in_frame_clken,
  input  logic [Y_BITS-1:0]    in_img_y,
  output logic                 out_frame_vsync,
  output logic                 out_frame_href,
  output logic                 out_frame_clken,
  output logic [Y_BITS-1:0]    out_img_y,
  output logic                 frame_done,
  output logic [FCNT_BITS-1:0] frame_cnt,
  output logic                 err_sticky,
  output logic [1:0]           err_code
);

  localparam logic [W_BITS-1:0]    W_ONE = {{(W_BITS-1){1'b0}}, 1'b1};
  localparam logic [FCNT_BITS-1:0] F_ONE = {{(FCNT_BITS-1){1'b0}}, 1'b1};

  state_t r_state, w_state_next;

  logic w_vs_rise, w_vs_fall, w_href_rise, w_href_fall;

  logic [W_BITS-1:0] r_width, r_height;
  logic              r_mode;
  logic [Y_BITS-1:0] r_val;
  logic [W_BITS-1:0] r_col, r_row;

  logic              r_vsync, r_href, r_clken, r_frame_done;
  logic [Y_BITS-1:0] r_y;
  logic [FCNT_BITS-1:0] r_frame_cnt;
  logic [1:0]        r_err;

  logic              w_start, w_active, w_pix, w_border;
  logic              w_line_end, w_frame_end;
  logic [W_BITS-1:0] w_width, w_height, w_col_inc, w_row_inc, w_row_final;
  logic              w_mode;
  logic [Y_BITS-1:0] w_val;
  logic [1:0]        w_new_err;

  // vsync history resets high so a reset taken mid-frame never sees a
  // spurious rise; the frame resumes only after vsync drops and rises again.
  vip_edge_detect #(.RST_VAL(1'b1)) u_vs_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (in_frame_vsync),
    .o_rise (w_vs_rise),
    .o_fall (w_vs_fall)
  );

  vip_edge_detect #(.RST_VAL(1'b0)) u_href_edge (
    .clk    (clk),
    .rst    (rst),
    .i_sig  (in_frame_href),
    .o_rise (w_href_rise),
    .o_fall (w_href_fall)
  );

  assign w_start     = w_vs_rise & (r_state == IDLE);
  assign w_active    = (r_state != IDLE) | w_start;
  assign w_pix       = w_active & in_frame_vsync & in_frame_href & in_frame_clken;
  assign w_line_end  = (r_state == LINE) & (w_href_fall | w_vs_fall);
  assign w_frame_end = (r_state != IDLE) & w_vs_fall;

  // The start cycle may already carry a pixel, so it sees the live config.
  assign w_width  = w_start ? cfg_width       : r_width;
  assign w_height = w_start ? cfg_height      : r_height;
  assign w_mode   = w_start ? cfg_border_mode : r_mode;
  assign w_val    = w_start ? cfg_border_val  : r_val;

  assign w_col_inc   = (r_col == '1) ? r_col : r_col + W_ONE;
  assign w_row_inc   = (r_row == '1) ? r_row : r_row + W_ONE;
  assign w_row_final = w_line_end ? w_row_inc : r_row;

  assign w_border = (r_row == '0) | (r_row == w_height - W_ONE) |
                    (r_col == '0) | (r_col == w_width - W_ONE);

  assign w_new_err = {w_frame_end & (w_row_final != r_height),
                      w_line_end  & (r_col != r_width)};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:       if (w_start) w_state_next = in_frame_href ? LINE : FRAME_WAIT;
      FRAME_WAIT: if (in_frame_href) w_state_next = LINE;
      LINE:       if (w_href_fall) w_state_next = LINE_GAP;
      LINE_GAP:   if (w_href_rise) w_state_next = LINE;
      default:    w_state_next = IDLE;
    endcase
    if (w_frame_end) w_state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_width  <= '0;
      r_height <= '0;
      r_mode   <= 1'b0;
      r_val    <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) begin
        r_width  <= cfg_width;
        r_height <= cfg_height;
        r_mode   <= cfg_border_mode;
        r_val    <= cfg_border_val;
      end
      if (w_frame_end | w_line_end) r_col <= '0;
      else if (w_pix)               r_col <= w_col_inc;
      if (w_frame_end)     r_row <= '0;
      else if (w_line_end) r_row <= w_row_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync      <= 1'b0;
      r_href       <= 1'b0;
      r_clken      <= 1'b0;
      r_y          <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
      r_err        <= ERR_NONE;
    end else begin
      r_vsync      <= in_frame_vsync;
      r_href       <= in_frame_href;
      r_clken      <= in_frame_clken;
      r_y          <= (w_pix & w_border & w_mode) ? w_val : in_img_y;
      r_frame_done <= w_frame_end;
      if (w_frame_end) r_frame_cnt <= r_frame_cnt + F_ONE;
      // New errors win over a simultaneous clear.
      r_err <= (r_err & ~(err_clr ? ERR_BOTH : ERR_NONE)) | w_new_err;
    end
  end

  assign out_frame_vsync = r_vsync;
  assign out_frame_href  = r_href;
  assign out_frame_clken = r_clken;
  assign out_img_y       = r_y;
  assign frame_done      = r_frame_done;
  assign frame_cnt       = r_frame_cnt;
  assign err_code        = r_err;
  assign err_sticky      = |r_err;

endmodule
